// File: rtl/mem_xbar_pkg.sv
// Shared constants and types for the mem_xbar crossbar and its arbiters.
package mem_xbar_pkg;

  localparam int unsigned MAX_PORTS = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // 0..NB_SLAVE-1 selects a slave; the value NB_SLAVE marks a decode error.
  typedef logic [$clog2(MAX_PORTS + 1)-1:0] tgt_t;

endpackage

// File: rtl/mem_xbar_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after ptr, and moves ptr past the winner on advance.
module rr_arb
  import mem_xbar_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              req,
  input  logic                      advance,
  output logic [idx_width(N)-1:0]   gnt_idx,
  output logic                      valid
);

  localparam int unsigned IW = idx_width(N);

  logic [IW-1:0]  ptr_q;
  logic [2*N-1:0] rot;
  logic [IW:0]    sum;

  // Rotating a doubled copy keeps every scan index a loop constant.
  always_comb begin
    rot     = {req, req} >> ptr_q;
    sum     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        sum   = {1'b0, ptr_q} + (IW + 1)'(k);
        if (sum >= (IW + 1)'(N)) begin
          sum = sum - (IW + 1)'(N);
        end
        gnt_idx = sum[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_xbar.sv
// Address-mapped request/grant crossbar with per-slave round-robin arbitration,
// tracked response routing and a local decode-error responder.
module mem_xbar
  import mem_xbar_pkg::*;
#(
  parameter int unsigned NB_MASTER  = 3,
  parameter int unsigned NB_SLAVE   = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] START_ADDR =
    {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] END_ADDR =
    {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF}
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NB_MASTER-1:0]                  m_req_i,
  input  logic [NB_MASTER*ADDR_WIDTH-1:0]       m_addr_i,
  input  logic [NB_MASTER-1:0]                  m_we_i,
  input  logic [NB_MASTER*(DATA_WIDTH/8)-1:0]   m_be_i,
  input  logic [NB_MASTER*DATA_WIDTH-1:0]       m_wdata_i,
  output logic [NB_MASTER-1:0]                  m_gnt_o,
  output logic [NB_MASTER-1:0]                  m_rvalid_o,
  output logic [NB_MASTER*DATA_WIDTH-1:0]       m_rdata_o,
  output logic [NB_MASTER-1:0]                  m_err_o,
  output logic [NB_SLAVE-1:0]                   s_req_o,
  output logic [NB_SLAVE*ADDR_WIDTH-1:0]        s_addr_o,
  output logic [NB_SLAVE-1:0]                   s_we_o,
  output logic [NB_SLAVE*(DATA_WIDTH/8)-1:0]    s_be_o,
  output logic [NB_SLAVE*DATA_WIDTH-1:0]        s_wdata_o,
  input  logic [NB_SLAVE-1:0]                   s_gnt_i,
  input  logic [NB_SLAVE-1:0]                   s_rvalid_i,
  input  logic [NB_SLAVE*DATA_WIDTH-1:0]        s_rdata_i
);

  localparam int unsigned BW  = DATA_WIDTH / 8;
  localparam int unsigned MIW = idx_width(NB_MASTER);
  localparam tgt_t        ERR = tgt_t'(NB_SLAVE);

  tgt_t                 tgt      [NB_MASTER];
  tgt_t                 target_q [NB_MASTER];
  logic [NB_MASTER-1:0] pending_q;
  logic [NB_MASTER-1:0] pend_eff;
  logic [NB_SLAVE-1:0]  busy_q;
  logic [NB_SLAVE-1:0]  busy_eff;
  logic [NB_SLAVE-1:0]  rsp;
  logic [MIW-1:0]       owner_q  [NB_SLAVE];
  logic [NB_MASTER-1:0] elig     [NB_SLAVE];
  logic [MIW-1:0]       win      [NB_SLAVE];
  logic [NB_SLAVE-1:0]  win_vld;
  logic [NB_SLAVE-1:0]  s_fire;

  // Descending scan so the lowest matching slave index overrides the rest.
  always_comb begin
    for (int unsigned m = 0; m < NB_MASTER; m++) begin
      tgt[m] = ERR;
      for (int unsigned i = NB_SLAVE; i > 0; i--) begin
        if (m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] >= START_ADDR[(i-1)*ADDR_WIDTH +: ADDR_WIDTH] &&
            m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] <= END_ADDR[(i-1)*ADDR_WIDTH +: ADDR_WIDTH]) begin
          tgt[m] = tgt_t'(i - 1);
        end
      end
    end
  end

  // Responses depend only on registered state and slave inputs, never on m_req_i.
  always_comb begin
    rsp        = s_rvalid_i & busy_q;
    busy_eff   = busy_q & ~s_rvalid_i;
    m_rvalid_o = '0;
    m_err_o    = '0;
    m_rdata_o  = '0;
    for (int unsigned m = 0; m < NB_MASTER; m++) begin
      if (pending_q[m] && target_q[m] == ERR) begin
        m_rvalid_o[m] = 1'b1;
        m_err_o[m]    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NB_SLAVE; i++) begin
      if (rsp[i]) begin
        m_rvalid_o[owner_q[i]] = 1'b1;
        m_rdata_o[owner_q[i]*DATA_WIDTH +: DATA_WIDTH] = s_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    pend_eff = pending_q & ~m_rvalid_o;
  end

  // A response retiring this cycle frees its master and slave for a back-to-back grant.
  always_comb begin
    for (int unsigned i = 0; i < NB_SLAVE; i++) begin
      for (int unsigned m = 0; m < NB_MASTER; m++) begin
        elig[i][m] = m_req_i[m] && !pend_eff[m] && (tgt[m] == tgt_t'(i)) && !busy_eff[i];
      end
    end
  end

  for (genvar i = 0; i < NB_SLAVE; i++) begin : g_arb
    rr_arb #(
      .N (NB_MASTER)
    ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (elig[i]),
      .advance (s_fire[i]),
      .gnt_idx (win[i]),
      .valid   (win_vld[i])
    );
  end

  assign s_fire = win_vld & s_gnt_i;

  always_comb begin
    s_req_o   = win_vld;
    s_addr_o  = '0;
    s_we_o    = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    m_gnt_o   = '0;
    for (int unsigned m = 0; m < NB_MASTER; m++) begin
      if (m_req_i[m] && !pend_eff[m] && tgt[m] == ERR) begin
        m_gnt_o[m] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NB_SLAVE; i++) begin
      s_addr_o[i*ADDR_WIDTH +: ADDR_WIDTH]  = m_addr_i[win[i]*ADDR_WIDTH +: ADDR_WIDTH];
      s_we_o[i]                             = m_we_i[win[i]];
      s_be_o[i*BW +: BW]                    = m_be_i[win[i]*BW +: BW];
      s_wdata_o[i*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[win[i]*DATA_WIDTH +: DATA_WIDTH];
      if (s_fire[i]) begin
        m_gnt_o[win[i]] = 1'b1;
      end
    end
  end

  // Set-on-grant is written after clear-on-response so the grant wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      busy_q    <= '0;
      for (int unsigned m = 0; m < NB_MASTER; m++) begin
        target_q[m] <= '0;
      end
      for (int unsigned i = 0; i < NB_SLAVE; i++) begin
        owner_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NB_SLAVE; i++) begin
        if (rsp[i]) begin
          busy_q[i] <= 1'b0;
        end
        if (s_fire[i]) begin
          busy_q[i]  <= 1'b1;
          owner_q[i] <= win[i];
        end
      end
      for (int unsigned m = 0; m < NB_MASTER; m++) begin
        if (m_rvalid_o[m]) begin
          pending_q[m] <= 1'b0;
        end
        if (m_gnt_o[m]) begin
          pending_q[m] <= 1'b1;
          target_q[m]  <= tgt[m];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_xbar.sv
// Scoreboard bench for mem_xbar: masters queue addresses, slaves answer with address-derived data.
module tb_mem_xbar;

  localparam int unsigned NM = 3;
  localparam int unsigned NS = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam logic [NS*AW-1:0] SA = {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] EA = {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NM-1:0]     m_req_i;
  logic [NM*AW-1:0]  m_addr_i;
  logic [NM-1:0]     m_we_i;
  logic [NM*BW-1:0]  m_be_i;
  logic [NM*DW-1:0]  m_wdata_i;
  logic [NM-1:0]     m_gnt_o;
  logic [NM-1:0]     m_rvalid_o;
  logic [NM*DW-1:0]  m_rdata_o;
  logic [NM-1:0]     m_err_o;
  logic [NS-1:0]     s_req_o;
  logic [NS*AW-1:0]  s_addr_o;
  logic [NS-1:0]     s_we_o;
  logic [NS*BW-1:0]  s_be_o;
  logic [NS*DW-1:0]  s_wdata_o;
  logic [NS-1:0]     s_gnt_i;
  logic [NS-1:0]     s_rvalid_i;
  logic [NS*DW-1:0]  s_rdata_i;
  logic [NS-1:0]     gnt_en;

  always #5 clk = ~clk;

  assign s_gnt_i = s_req_o & gnt_en;

  mem_xbar #(
    .NB_MASTER  (NM),
    .NB_SLAVE   (NS),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .START_ADDR (SA),
    .END_ADDR   (EA)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_req_i    (m_req_i),
    .m_addr_i   (m_addr_i),
    .m_we_i     (m_we_i),
    .m_be_i     (m_be_i),
    .m_wdata_i  (m_wdata_i),
    .m_gnt_o    (m_gnt_o),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .m_err_o    (m_err_o),
    .s_req_o    (s_req_o),
    .s_addr_o   (s_addr_o),
    .s_we_o     (s_we_o),
    .s_be_o     (s_be_o),
    .s_wdata_o  (s_wdata_o),
    .s_gnt_i    (s_gnt_i),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  logic [31:0]  mq    [NM][$];
  logic [32:0]  exp_q [NM][$];
  logic         act     [NM];
  logic         granted [NM];
  int unsigned  req_cyc [NM];
  int unsigned  gnt_cyc [NM];
  int unsigned  rv_cyc  [NM];
  int unsigned  gnt_log [$];
  int unsigned  lat     [NS];
  int unsigned  cnt     [NS];
  logic [31:0]  sl_addr [NS];
  logic         inj_rv  [NS];
  logic [NM-1:0] smp_gnt, smp_rv;
  logic [NS-1:0] smp_sreq;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] key(input int unsigned s);
    case (s)
      0:       return 32'hCAFE_F01D;
      1:       return 32'h1234_5678;
      default: return 32'h0BAD_BEEF;
    endcase
  endfunction

  // Independent copy of the address map: {err, rdata} the master should see.
  function automatic logic [32:0] expect_of(input logic [31:0] a);
    logic [31:0] lo [NS];
    logic [31:0] hi [NS];
    lo = '{32'h0000_0000, 32'h0010_0000, 32'h1A10_0000};
    hi = '{32'h000F_FFFF, 32'h001F_FFFF, 32'h1A11_FFFF};
    for (int unsigned s = 0; s < NS; s++) begin
      if (a >= lo[s] && a <= hi[s]) return {1'b0, a ^ key(s)};
    end
    return {1'b1, 32'h0};
  endfunction

  function automatic logic is_idle();
    for (int unsigned m = 0; m < NM; m++) begin
      if (mq[m].size() != 0 || exp_q[m].size() != 0 || act[m]) return 1'b0;
    end
    for (int unsigned s = 0; s < NS; s++) begin
      if (cnt[s] != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Sample at negedge, then drive just after the following posedge.
  task automatic cycle();
    logic [32:0] e;
    logic [31:0] a;
    @(negedge clk);
    smp_gnt  = m_gnt_o;
    smp_rv   = m_rvalid_o;
    smp_sreq = s_req_o;
    for (int unsigned m = 0; m < NM; m++) begin
      if (m_gnt_o[m]) begin
        if (act[m]) begin
          granted[m] = 1'b1;
          gnt_cyc[m] = cyc;
          gnt_log.push_back(m);
        end else begin
          check_val($sformatf("gnt_idle_m%0d", m), 64'(m_gnt_o[m]), 64'd0);
        end
      end
      if (m_rvalid_o[m]) begin
        rv_cyc[m] = cyc;
        if (exp_q[m].size() == 0) begin
          check_val($sformatf("rvalid_unexp_m%0d", m), 64'(m_rvalid_o[m]), 64'd0);
        end else begin
          e = exp_q[m].pop_front();
          check_val($sformatf("rdata_m%0d", m), 64'(m_rdata_o[m*DW +: DW]), 64'(e[31:0]));
          check_val($sformatf("err_m%0d", m), 64'(m_err_o[m]), 64'(e[32]));
        end
      end
    end
    for (int unsigned s = 0; s < NS; s++) begin
      if (s_req_o[s] && s_gnt_i[s]) begin
        sl_addr[s] = s_addr_o[s*AW +: AW];
        cnt[s]     = lat[s];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    s_rvalid_i = '0;
    s_rdata_i  = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      if (inj_rv[s]) s_rvalid_i[s] = 1'b1;
      inj_rv[s] = 1'b0;
      if (cnt[s] > 0) begin
        cnt[s]--;
        if (cnt[s] == 0) begin
          s_rvalid_i[s]            = 1'b1;
          s_rdata_i[s*DW +: DW]    = sl_addr[s] ^ key(s);
        end
      end
    end
    for (int unsigned m = 0; m < NM; m++) begin
      if (granted[m]) begin
        act[m]     = 1'b0;
        m_req_i[m] = 1'b0;
        granted[m] = 1'b0;
      end
      if (!act[m] && mq[m].size() != 0) begin
        a                      = mq[m].pop_front();
        act[m]                 = 1'b1;
        m_req_i[m]             = 1'b1;
        m_addr_i[m*AW +: AW]   = a;
        m_we_i[m]              = a[2];
        m_be_i[m*BW +: BW]     = '1;
        m_wdata_i[m*DW +: DW]  = ~a;
        req_cyc[m]             = cyc;
        exp_q[m].push_back(expect_of(a));
      end
    end
  endtask

  task automatic wait_idle(input int unsigned budget, input string tag);
    for (int unsigned i = 0; i < budget; i++) begin
      if (is_idle()) break;
      cycle();
    end
    check_val(tag, 64'(is_idle()), 64'd1);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    m_req_i    = '0;
    s_rvalid_i = '0;
    s_rdata_i  = '0;
    for (int unsigned m = 0; m < NM; m++) begin
      act[m]     = 1'b0;
      granted[m] = 1'b0;
      mq[m].delete();
      exp_q[m].delete();
    end
    for (int unsigned s = 0; s < NS; s++) begin
      cnt[s]    = 0;
      inj_rv[s] = 1'b0;
    end
    @(negedge clk);
    check_val("rst_gnt",    64'(m_gnt_o),    64'd0);
    check_val("rst_rvalid", 64'(m_rvalid_o), 64'd0);
    check_val("rst_err",    64'(m_err_o),    64'd0);
    check_val("rst_sreq",   64'(s_req_o),    64'd0);
    check_val("rst_rdata",  64'(m_rdata_o),  64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    m_req_i   = '0;
    m_addr_i  = '0;
    m_we_i    = '0;
    m_be_i    = '0;
    m_wdata_i = '0;
    gnt_en    = '1;
    lat       = '{3, 3, 3};
    @(posedge clk);
    #1;
    do_reset();

    // Single access, slave 0 answers three cycles after the grant.
    mq[0].push_back(32'h0000_0010);
    wait_idle(40, "s1_idle");
    check_val("s1_gnt_lat", 64'(gnt_cyc[0] - req_cyc[0]), 64'd0);
    check_val("s1_rv_lat",  64'(rv_cyc[0] - gnt_cyc[0]),  64'd3);

    // Contention on slave 2 with single-cycle latency.
    do_reset();
    lat = '{3, 3, 1};
    gnt_log.delete();
    for (int unsigned k = 0; k < 4; k++) begin
      for (int unsigned m = 0; m < NM; m++) begin
        mq[m].push_back(32'h1A10_0000 + 32'(4 * (m * 4 + k)));
      end
    end
    wait_idle(100, "s2_idle");
    check_val("s2_count", 64'(gnt_log.size()), 64'd12);
    for (int unsigned j = 0; j < gnt_log.size(); j++) begin
      check_val($sformatf("s2_order%0d", j), 64'(gnt_log[j]), 64'(j % NM));
    end

    // Two masters to two different slaves in the same cycle.
    lat = '{2, 2, 2};
    mq[0].push_back(32'h0000_0100);
    mq[1].push_back(32'h0010_0040);
    wait_idle(40, "s3_idle");
    check_val("s3_same_cycle", 64'(gnt_cyc[1]), 64'(gnt_cyc[0]));
    check_val("s3_gnt_lat",    64'(gnt_cyc[0] - req_cyc[0]), 64'd0);

    // Decode error: immediate grant, error response next cycle, no slave request.
    mq[2].push_back(32'h2000_0000);
    cycle();
    cycle();
    check_val("s4_gnt",     64'(smp_gnt[2]), 64'd1);
    check_val("s4_no_sreq", 64'(smp_sreq),   64'd0);
    cycle();
    check_val("s4_rv", 64'(smp_rv[2]), 64'd1);
    wait_idle(10, "s4_idle");

    // Range edges on both sides of every slave window.
    lat = '{1, 1, 1};
    mq[0].push_back(32'h000F_FFFF);
    mq[0].push_back(32'h0010_0000);
    mq[0].push_back(32'h001F_FFFF);
    mq[0].push_back(32'h0020_0000);
    mq[0].push_back(32'h1A0F_FFFF);
    mq[0].push_back(32'h1A10_0000);
    mq[0].push_back(32'h1A11_FFFF);
    mq[0].push_back(32'h1A12_0000);
    mq[0].push_back(32'hFFFF_FFFF);
    wait_idle(100, "bnd_idle");

    // Back-to-back: response and next grant on the same master and slave.
    mq[0].push_back(32'h0000_0040);
    mq[0].push_back(32'h0000_0044);
    cycle();
    cycle();
    check_val("s5_gnt1", 64'(smp_gnt[0]), 64'd1);
    cycle();
    check_val("s5_rv1",      64'(smp_rv[0]),  64'd1);
    check_val("s5_b2b_gnt",  64'(smp_gnt[0]), 64'd1);
    cycle();
    check_val("s5_rv2", 64'(smp_rv[0]), 64'd1);
    wait_idle(10, "s5_idle");

    // Reset while slave 1 is busy; its late response must vanish.
    lat = '{1, 8, 1};
    mq[1].push_back(32'h0010_0000);
    cycle();
    cycle();
    check_val("s6_gnt", 64'(smp_gnt[1]), 64'd1);
    cycle();
    cycle();
    do_reset();
    lat = '{1, 2, 1};
    inj_rv[1] = 1'b1;
    mq[0].push_back(32'h0010_0004);
    cycle();
    cycle();
    check_val("s6_late_rv",       64'(smp_rv),     64'd0);
    check_val("s6_gnt_after_rst", 64'(smp_gnt[0]), 64'd1);
    wait_idle(20, "s6_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
